// File: rtl/neuron_array_tdm_if.sv
// Handshake bundle for neuron_array_tdm.
//   in_valid/in_ready/in_idx/in_mac_sum : update requests toward the neuron array
//   out_valid/out_idx/out_spike/out_vmem : one-cycle result beat per update
// master drives requests and observes results; slave is the neuron array.
interface neuron_array_tdm_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_W      = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IDX_W-1:0]      in_idx;
    logic [DATA_WIDTH-1:0] in_mac_sum;
    logic                  out_valid;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_spike;
    logic [DATA_WIDTH-1:0] out_vmem;

    modport master (
        output in_valid, in_idx, in_mac_sum,
        input  in_ready, out_valid, out_idx, out_spike, out_vmem
    );

    modport slave (
        input  in_valid, in_idx, in_mac_sum,
        output in_ready, out_valid, out_idx, out_spike, out_vmem
    );
endinterface

// File: rtl/neuron_array_tdm.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update
// datapath. Each accepted {idx, mac_sum} updates one neuron; a tick pulse runs a
// leak-only sweep over all neurons (input blocked meanwhile). Every update yields a
// registered result beat one cycle later.
// Ports:
//   clk, rst_n (async, active-low)
//   tick        : one-cycle sweep request; ticks during a sweep queue one more sweep
//   bus (slave) : input handshake and result beat, see neuron_array_tdm_if
//   spike_count : saturating 16-bit spike counter, present only when
//                 NEURON_ARRAY_STATS_EN is defined
module neuron_array_tdm #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned N_NEURONS   = 4,
    parameter int unsigned IDX_W       = $clog2(N_NEURONS),
    parameter int unsigned THRESH      = 15,
    parameter int unsigned THRESH_HIGH = 40,
    parameter int unsigned REF_EXIT    = 70,
    parameter int unsigned MAX_VAL     = 100,
    parameter int unsigned LEAK_IDLE   = 2,
    parameter int unsigned LEAK_REF    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
`ifdef NEURON_ARRAY_STATS_EN
    output logic [15:0] spike_count,
`endif
    neuron_array_tdm_if.slave bus
);
    localparam int unsigned DW1    = DATA_WIDTH + 1;
    localparam int unsigned IDX_W1 = IDX_W + 1;

    typedef enum logic [1:0] {NIdle = 2'd0, NAbsRef = 2'd1, NRelRef = 2'd2} nstate_e;
    typedef enum logic {CReady = 1'b0, CSweep = 1'b1} cstate_e;

    nstate_e               st_q   [N_NEURONS];
    logic [DATA_WIDTH-1:0] vmem_q [N_NEURONS];

    cstate_e          ctrl_q, ctrl_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             pend_q, pend_d;

    logic                  sweep, accept, in_range, upd_en;
    logic [IDX_W-1:0]      upd_idx, rd_idx;
    logic [DATA_WIDTH-1:0] v, s, new_v;
    logic [DW1-1:0]        leak, sum, c;
    nstate_e               cur, new_st;
    logic                  spike;

    logic                  out_valid_q, out_spike_q;
    logic [IDX_W-1:0]      out_idx_q;
    logic [DATA_WIDTH-1:0] out_vmem_q;

    assign sweep        = (ctrl_q == CSweep);
    assign bus.in_ready = (ctrl_q == CReady);
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_range     = {1'b0, bus.in_idx} < IDX_W1'(N_NEURONS);

    // Shared update datapath
    always_comb begin
        upd_en  = sweep || (accept && in_range);
        upd_idx = sweep ? k_q : bus.in_idx;
        // Keep the array read in range when nothing is being updated
        rd_idx  = upd_en ? upd_idx : '0;
        v       = vmem_q[rd_idx];
        cur     = st_q[rd_idx];
        s       = sweep ? '0 : bus.in_mac_sum;
        leak    = (cur == NIdle) ? DW1'(LEAK_IDLE) : DW1'(LEAK_REF);
        sum     = {1'b0, v} + {1'b0, s};
        c       = (sum <= leak) ? '0 : sum - leak;
        if (c >= DW1'(MAX_VAL)) begin
            c = DW1'(MAX_VAL);
        end
        new_st = cur;
        new_v  = c[DATA_WIDTH-1:0];
        spike  = 1'b0;
        case (cur)
            NIdle: begin
                if (c >= DW1'(THRESH)) begin
                    spike  = 1'b1;
                    new_v  = DATA_WIDTH'(MAX_VAL);
                    new_st = NAbsRef;
                end
            end
            NAbsRef: begin
                // Input is ignored; fixed decay toward the relative-refractory band
                new_v = (v > DATA_WIDTH'(LEAK_REF)) ? v - DATA_WIDTH'(LEAK_REF) : '0;
                if (new_v <= DATA_WIDTH'(REF_EXIT)) begin
                    new_st = NRelRef;
                end
            end
            NRelRef: begin
                // Sweep updates can never re-fire a refractory neuron
                if (!sweep && c >= DW1'(THRESH_HIGH)) begin
                    spike  = 1'b1;
                    new_v  = DATA_WIDTH'(MAX_VAL);
                    new_st = NAbsRef;
                end else if (c == '0) begin
                    new_st = NIdle;
                    new_v  = '0;
                end
            end
            default: begin
                new_st = NIdle;
                new_v  = '0;
            end
        endcase
    end

    // Sweep controller next state
    always_comb begin
        ctrl_d = ctrl_q;
        k_d    = k_q;
        pend_d = pend_q;
        case (ctrl_q)
            CReady: begin
                if (tick) begin
                    ctrl_d = CSweep;
                    k_d    = '0;
                end
            end
            CSweep: begin
                if (k_q == IDX_W'(N_NEURONS - 1)) begin
                    k_d = '0;
                    // A tick landing on the final step still queues a rerun
                    if (pend_q || tick) begin
                        pend_d = 1'b0;
                    end else begin
                        ctrl_d = CReady;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                    if (tick) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: ctrl_d = CReady;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CReady;
            k_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            k_q    <= k_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                st_q[i]   <= NIdle;
                vmem_q[i] <= '0;
            end
        end else if (upd_en) begin
            st_q[upd_idx]   <= new_st;
            vmem_q[upd_idx] <= new_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_spike_q <= 1'b0;
            out_idx_q   <= '0;
            out_vmem_q  <= '0;
        end else begin
            out_valid_q <= upd_en;
            out_spike_q <= upd_en && spike;
            if (upd_en) begin
                out_idx_q  <= upd_idx;
                out_vmem_q <= new_v;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_spike = out_spike_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_vmem  = out_vmem_q;

`ifdef NEURON_ARRAY_STATS_EN
    logic [15:0] spike_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count_q <= '0;
        end else if (out_valid_q && out_spike_q && spike_count_q != 16'hFFFF) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`endif
endmodule

// File: tb/tb_neuron_array_tdm.sv
module tb_neuron_array_tdm;
    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int N5  = 5;
    localparam int IW5 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;
    logic tick5 = 1'b0;

    always #5 clk = ~clk;

    neuron_array_tdm_if #(.DATA_WIDTH(DW), .IDX_W(IW))  bus  ();
    neuron_array_tdm_if #(.DATA_WIDTH(DW), .IDX_W(IW5)) bus5 ();

`ifdef NEURON_ARRAY_STATS_EN
    logic [15:0] spike_count;
    logic [15:0] spike_count5;
`endif

    neuron_array_tdm #(.DATA_WIDTH(DW), .N_NEURONS(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
`ifdef NEURON_ARRAY_STATS_EN
        .spike_count(spike_count),
`endif
        .bus(bus)
    );

    // Non-power-of-two array for out-of-range drop and sweep wrap
    neuron_array_tdm #(.DATA_WIDTH(DW), .N_NEURONS(N5)) dut5 (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick5),
`ifdef NEURON_ARRAY_STATS_EN
        .spike_count(spike_count5),
`endif
        .bus(bus5)
    );

    typedef struct {
        bit tk;
        int idx;
        int sum;
        int sp;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    typedef struct {
        int idx;
        int sp;
        int vm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[19];
    int checks = 0;
    int errors = 0;
    int exp_spikes = 0;
    int lowrun = 0;
    int last_low = 0;
    int beats5 = 0;
    int last_idx5 = -1;
    int last_v5 = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int s, input int v);
        exp_t e;
        e.idx = i;
        e.sp  = s;
        e.vm  = v;
        sb.push_back(e);
    endtask

    // Scoreboard: every result beat must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx %0d vmem %0d, expected no beat",
                         bus.out_idx, bus.out_vmem);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.sp != 0) exp_spikes++;
                if (int'(bus.out_idx) != e.idx || int'(bus.out_spike) != e.sp ||
                    int'(bus.out_vmem) != e.vm) begin
                    errors++;
                    $display("FAIL beat: got idx/spike/vmem %0d/%0d/%0d expected %0d/%0d/%0d",
                             bus.out_idx, bus.out_spike, bus.out_vmem, e.idx, e.sp, e.vm);
                end
            end
        end
    end

    // Length of the most recent run of in_ready-low cycles
    always @(negedge clk) begin
        if (!bus.in_ready) begin
            lowrun++;
        end else begin
            if (lowrun != 0) last_low = lowrun;
            lowrun = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus5.out_valid) begin
            beats5++;
            last_idx5 = int'(bus5.out_idx);
            last_v5   = int'(bus5.out_vmem);
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.in_ready) break;
        end
        chk("ready_timeout", int'(bus.in_ready), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send(input int i, input int s, input int sp, input int v);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b1;
        bus.in_idx     = IW'(i);
        bus.in_mac_sum = DW'(s);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        chk("send_ready", int'(bus.in_ready), 1);
        push(i, sp, v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_tick(input int e0, input int e1, input int e2, input int e3);
        @(posedge clk);
        #1;
        tick = 1'b1;
        push(0, 0, e0);
        push(1, 0, e1);
        push(2, 0, e2);
        push(3, 0, e3);
        @(posedge clk);
        #1;
        tick = 1'b0;
        wait_ready();
        chk("sweep_len", last_low, N);
        drain();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_out_spike", int'(bus.out_spike), 0);
        chk("rst_out_vmem", int'(bus.out_vmem), 0);
`ifdef NEURON_ARRAY_STATS_EN
        chk("rst_spike_count", int'(spike_count), 0);
`endif
    endtask

    initial begin
        // inputs: tk, idx, sum; expected: spike, vmem (sweeps: vmem of neurons 0..3)
        tbl[0]  = '{0, 2, 10,  0, 8,   0,  0,  0};
        tbl[1]  = '{0, 2, 10,  1, 100, 0,  0,  0};
        tbl[2]  = '{0, 0, 5,   0, 3,   0,  0,  0};
        tbl[3]  = '{0, 1, 1,   0, 0,   0,  0,  0};
        tbl[4]  = '{0, 3, 14,  0, 12,  0,  0,  0};
        tbl[5]  = '{0, 3, 2,   0, 12,  0,  0,  0};
        tbl[6]  = '{1, 0, 0,   0, 1,   0,  80, 10};
        tbl[7]  = '{1, 0, 0,   0, 0,   0,  60, 8};
        tbl[8]  = '{0, 2, 5,   1, 100, 0,  0,  0};
        tbl[9]  = '{0, 2, 200, 0, 80,  0,  0,  0};
        tbl[10] = '{0, 3, 250, 1, 100, 0,  0,  0};
        tbl[11] = '{0, 1, 16,  0, 14,  0,  0,  0};
        tbl[12] = '{1, 0, 0,   0, 0,   12, 60, 80};
        tbl[13] = '{1, 0, 0,   0, 0,   10, 40, 60};
        tbl[14] = '{1, 0, 0,   0, 0,   8,  20, 40};
        tbl[15] = '{0, 2, 0,   0, 0,   0,  0,  0};
        tbl[16] = '{0, 3, 20,  1, 100, 0,  0,  0};
        tbl[17] = '{0, 1, 9,   1, 100, 0,  0,  0};
        tbl[18] = '{0, 2, 2,   0, 0,   0,  0,  0};

        bus.in_valid    = 1'b0;
        bus.in_idx      = '0;
        bus.in_mac_sum  = '0;
        bus5.in_valid   = 1'b0;
        bus5.in_idx     = '0;
        bus5.in_mac_sum = '0;

        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].tk) do_tick(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
            else           send(tbl[i].idx, tbl[i].sum, tbl[i].sp, tbl[i].e0);
        end
        drain();

        // Tick with an accepted input, second tick two cycles later, next input held
        @(posedge clk);
        #1;
        tick           = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_idx     = 2'd0;
        bus.in_mac_sum = 8'd4;
        push(0, 0, 2);
        push(0, 0, 0);
        push(1, 0, 80);
        push(2, 0, 0);
        push(3, 0, 80);
        push(0, 0, 0);
        push(1, 0, 60);
        push(2, 0, 0);
        push(3, 0, 60);
        push(2, 1, 100);
        @(posedge clk);
        #1;
        tick           = 1'b0;
        bus.in_idx     = 2'd2;
        bus.in_mac_sum = 8'd20;
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        wait_ready();
        chk("pend_sweep_len", last_low, 2 * N);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
`ifdef NEURON_ARRAY_STATS_EN
        @(posedge clk);
        #1;
        chk("spike_count", int'(spike_count), exp_spikes);
`endif

        // Out-of-range indices are dropped; then a 5-neuron sweep
        @(posedge clk);
        #1;
        bus5.in_valid   = 1'b1;
        bus5.in_idx     = 3'd5;
        bus5.in_mac_sum = 8'd50;
        @(posedge clk);
        #1;
        bus5.in_idx = 3'd7;
        @(posedge clk);
        #1;
        bus5.in_idx     = 3'd4;
        bus5.in_mac_sum = 8'd10;
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_beats", beats5, 1);
        chk("drop_last_idx", last_idx5, 4);
        chk("drop_last_vmem", last_v5, 8);
        tick5 = 1'b1;
        @(posedge clk);
        #1;
        tick5 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus5.in_ready) break;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("sweep5_beats", beats5, 1 + N5);
        chk("sweep5_last_idx", last_idx5, 4);
        chk("sweep5_last_vmem", last_v5, 6);

        // Reset during the third sweep cycle
        @(posedge clk);
        #1;
        tick = 1'b1;
        push(0, 0, 0);
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        exp_spikes = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send(i, 2, 0, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
